cardinal_nic: RTL

- Network interface controller between one Cardinal processor's NIC port and its node's bidirectional ring router.
- Exposes one 64-bit input channel buffer and one 64-bit output channel buffer to the processor, plus a status register for each, as 4 memory-mapped locations.
- Moves packets to and from the router over a ready/send handshake, gated by the ring's virtual-channel polarity.
- One instance per node (4 per cmp).

---
 rtl/cardinal_nic_if.sv | 30 +++
 rtl/cardinal_nic.sv | 72 +++++++
 2 files changed

// File: rtl/cardinal_nic_if.sv
// Processor register bus and ring-router handshake for one Cardinal NIC.
// Bit 0 of every data word is the MSB (big-endian numbering).
interface cardinal_nic_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [0:DATA_WIDTH-1] d_in;
    logic [0:DATA_WIDTH-1] d_out;
    logic                  nicEn;
    logic                  nicWrEn;
    logic                  net_si;
    logic                  net_ri;
    logic [0:DATA_WIDTH-1] net_di;
    logic                  net_so;
    logic                  net_ro;
    logic [0:DATA_WIDTH-1] net_do;
    logic                  net_polarity;

    // master: processor + router side driving the NIC
    modport master (
        output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );

    modport slave (
        input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );
endinterface

// File: rtl/cardinal_nic.sv
// Cardinal NIC: one-deep input and output channel buffers between the processor
// register bus and the ring router, with VC-polarity gated injection.
module cardinal_nic #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
) (
    input logic           clk,
    input logic           reset,
    cardinal_nic_if.slave nic
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IB     = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IB_ST  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OB     = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OB_ST  = ADDR_WIDTH'(3);

    logic [0:DATA_WIDTH-1] ib_data;
    logic [0:DATA_WIDTH-1] ob_data;
    logic                  ib_full;
    logic                  ob_full;
    logic                  rd_en;
    logic                  wr_en;
    logic                  send;

    assign rd_en = nic.nicEn & ~nic.nicWrEn;
    assign wr_en = nic.nicEn & nic.nicWrEn;

    assign nic.net_ri = ~ib_full;

    // Bit 0 of the held packet selects the virtual channel.
    assign send       = ob_full & nic.net_ro & (ob_data[0] == nic.net_polarity);
    assign nic.net_so = send;
    assign nic.net_do = send ? ob_data : '0;

    always_comb begin
        nic.d_out = '0;
        if (rd_en) begin
            case (nic.addr)
                ADDR_IB:    nic.d_out = ib_data;
                ADDR_IB_ST: nic.d_out = {{(DATA_WIDTH-1){1'b0}}, ib_full};
                ADDR_OB:    nic.d_out = ob_data;
                ADDR_OB_ST: nic.d_out = {{(DATA_WIDTH-1){1'b0}}, ob_full};
                default:    nic.d_out = '0;
            endcase
        end
    end

    // Deposit needs an empty buffer and the drain needs a full one, so they never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ib_data <= '0;
            ib_full <= 1'b0;
        end else if (nic.net_si && !ib_full) begin
            ib_data <= nic.net_di;
            ib_full <= 1'b1;
        end else if (rd_en && (nic.addr == ADDR_IB) && ib_full) begin
            ib_full <= 1'b0;
        end
    end

    // A write landing in the same cycle as the send still sees a full buffer and is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ob_data <= '0;
            ob_full <= 1'b0;
        end else if (send) begin
            ob_full <= 1'b0;
        end else if (wr_en && (nic.addr == ADDR_OB) && !ob_full) begin
            ob_data <= nic.d_in;
            ob_full <= 1'b1;
        end
    end
endmodule
